// File: rtl/mul_issue_if.sv
// Bundle of the EX-side request, write-back response and Booth multiplier control
// signals around mul_issue. The slave modport is the block itself.
interface mul_issue_if #(
  parameter int XLEN = 64
);
  logic            ex_valid;
  logic            ex_ready;
  logic [1:0]      ex_op;
  logic            ex_word;
  logic [XLEN-1:0] ex_src1;
  logic [XLEN-1:0] ex_src2;
  logic [4:0]      ex_rd;
  logic            flush;

  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;

  logic            mul_in_valid;
  logic            mul_flush;
  logic            mul_mulw;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] mul_multiplicand;
  logic [XLEN-1:0] mul_multiplier;
  logic            mul_out_ready;
  logic            mul_out_valid;
  logic [XLEN-1:0] mul_result_hi;
  logic [XLEN-1:0] mul_result_lo;

  modport slave (
    input  ex_valid, ex_op, ex_word, ex_src1, ex_src2, ex_rd, flush,
    input  wb_ready,
    input  mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
    output ex_ready, wb_valid, wb_data, wb_rd,
    output mul_in_valid, mul_flush, mul_mulw, mul_signed,
    output mul_multiplicand, mul_multiplier
  );

  modport master (
    output ex_valid, ex_op, ex_word, ex_src1, ex_src2, ex_rd, flush,
    output wb_ready,
    output mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
    input  ex_ready, wb_valid, wb_data, wb_rd,
    input  mul_in_valid, mul_flush, mul_mulw, mul_signed,
    input  mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/mul_issue.sv
// Issue/capture controller in front of the Booth multiplier: latches one RV64M
// multiply, issues it, selects the result half and holds it for write-back.
module mul_issue #(
  parameter int XLEN = 64
) (
  input  logic       clock,
  input  logic       reset,
  mul_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic            stale_q, stale_d;
  logic            accept, capture, issue_fire;

  logic [1:0]      op_p0;
  logic            word_p0;
  logic [4:0]      rd_p0;
  logic [1:0]      signed_p0;
  logic [XLEN-1:0] mcand_p0;
  logic [XLEN-1:0] mplier_p0;
  logic [XLEN-1:0] wb_data_p1;

  // Operand signedness: bit 1 for rs1, bit 0 for rs2.
  function automatic logic [1:0] mul_signedness(input logic [1:0] op, input logic word);
    logic [1:0] sg;
    sg = 2'b11;
    if (!word) begin
      case (op)
        2'b10:   sg = 2'b10;
        2'b11:   sg = 2'b00;
        default: sg = 2'b11;
      endcase
    end
    return sg;
  endfunction

  function automatic logic [XLEN-1:0] select_result(input logic [1:0]      op,
                                                    input logic            word,
                                                    input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo);
    logic signed [31:0] lo_w;
    lo_w = lo[31:0];
    if (word)
      return XLEN'(lo_w);
    else if (op == 2'b00)
      return lo;
    else
      return hi;
  endfunction

  assign issue_fire           = (state_q == ISSUE) && bus.mul_out_ready && !stale_q;
  assign bus.mul_in_valid     = issue_fire;
  assign bus.mul_flush        = bus.flush && (state_q == WAIT);
  assign bus.ex_ready         = (state_q == IDLE);
  assign bus.wb_valid         = (state_q == DONE);
  assign bus.wb_data          = wb_data_p1;
  assign bus.wb_rd            = rd_p0;
  assign bus.mul_mulw         = word_p0;
  assign bus.mul_signed       = signed_p0;
  assign bus.mul_multiplicand = mcand_p0;
  assign bus.mul_multiplier   = mplier_p0;

  always_comb begin
    state_d = state_q;
    stale_d = stale_q;
    accept  = 1'b0;
    capture = 1'b0;
    // An owed result from a flushed op is swallowed whenever it shows up.
    if (stale_q && bus.mul_out_valid)
      stale_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && bus.ex_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.flush) begin
          state_d = IDLE;
          // The multiplier took the op this cycle, so its result is still owed.
          if (issue_fire)
            stale_d = 1'b1;
        end else if (issue_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = IDLE;
          stale_d = !bus.mul_out_valid;
        end else if (bus.mul_out_valid) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.flush || bus.wb_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stale_q <= stale_d;
    end
  end

  // Stage p0: operands and op latched at EX accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_p0     <= '0;
      word_p0   <= 1'b0;
      rd_p0     <= '0;
      signed_p0 <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
    end else if (accept) begin
      op_p0     <= bus.ex_op;
      word_p0   <= bus.ex_word;
      rd_p0     <= bus.ex_rd;
      signed_p0 <= mul_signedness(bus.ex_op, bus.ex_word);
      mcand_p0  <= bus.ex_src1;
      mplier_p0 <= bus.ex_src2;
    end
  end

  // Stage p1: selected result captured on the multiplier's result pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wb_data_p1 <= '0;
    else if (capture)
      wb_data_p1 <= select_result(op_p0, word_p0, bus.mul_result_hi, bus.mul_result_lo);
  end

endmodule
